game_cmd_sequencer: RTL and testbench

- Sequences player commands into the game core's single-cycle control inputs: game_area, retract, retry, left, right, plus cursor.
- Arbitrates round-robin between two requesters: requester 0 is the keyboard decoder, requester 1 is the mouse/click decoder.
- Guarantees each game-core command is a clean one-cycle pulse with a stable cursor, followed by a settle gap so state, step and stage registers update before the next command.
- Sits between the input decoders and the game core.

---
 rtl/game_cmd_pkg.sv | 27 ++
 rtl/game_rr_arbiter.sv | 17 +
 rtl/game_cmd_sequencer.sv | 124 ++++++++++++
 tb/tb_game_cmd_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_cmd_pkg.sv
// Shared encodings for the game command sequencer.
// Command codes, FSM states and the one-hot pulse layout.
package game_cmd_pkg;

  localparam int CUR_W = 6;

  localparam logic [2:0] CMD_NOP     = 3'd0;
  localparam logic [2:0] CMD_MOVE    = 3'd1;
  localparam logic [2:0] CMD_RETRACT = 3'd2;
  localparam logic [2:0] CMD_RETRY   = 3'd3;
  localparam logic [2:0] CMD_PREV    = 3'd4;
  localparam logic [2:0] CMD_NEXT    = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  // Pulse bundle order: {game_area, retract, retry, left, right}
  localparam logic [4:0] P_AREA    = 5'b10000;
  localparam logic [4:0] P_RETRACT = 5'b01000;
  localparam logic [4:0] P_RETRY   = 5'b00100;
  localparam logic [4:0] P_LEFT    = 5'b00010;
  localparam logic [4:0] P_RIGHT   = 5'b00001;

endpackage

// File: rtl/game_rr_arbiter.sv
// Two-way round-robin grant logic, purely combinational.
// The owner keeps the last_grant register.
module game_rr_arbiter (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  // On a tie the requester not served last wins
  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = (req0 & req1) ? ~last_grant : req1;
  end

endmodule

// File: rtl/game_cmd_sequencer.sv
// Turns decoder requests into one-cycle game-core pulses,
// each followed by a settle gap before the next capture.
module game_cmd_sequencer
  import game_cmd_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int CMD_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [CMD_W-1:0] cmd0,
  input  logic [CUR_W-1:0] cur0,
  output logic             ack0,
  input  logic             req1,
  input  logic [CMD_W-1:0] cmd1,
  input  logic [CUR_W-1:0] cur1,
  output logic             ack1,
  input  logic             win,
  output logic [CUR_W-1:0] cursor,
  output logic             game_area,
  output logic             retract,
  output logic             retry,
  output logic             left,
  output logic             right,
  output logic             busy,
  output logic             drop
);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [4:0]       pls_q, pls_d;
  logic [CUR_W-1:0] cur_q, cur_d;

  logic             gnt_v, gnt_id;
  logic [CMD_W-1:0] sel_cmd;
  logic [CUR_W-1:0] sel_cur;
  logic [4:0]       dec;
  logic             ok;

  game_rr_arbiter u_arb (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_q),
    .grant_valid (gnt_v),
    .grant_id    (gnt_id)
  );

  // Decode the granted command; board-changing moves die on a win
  always_comb begin
    sel_cmd = gnt_id ? cmd1 : cmd0;
    sel_cur = gnt_id ? cur1 : cur0;
    dec     = '0;
    ok      = 1'b0;
    case (sel_cmd)
      CMD_W'(CMD_MOVE):    begin dec = P_AREA;    ok = ~win; end
      CMD_W'(CMD_RETRACT): begin dec = P_RETRACT; ok = ~win; end
      CMD_W'(CMD_RETRY):   begin dec = P_RETRY;   ok = ~win; end
      CMD_W'(CMD_PREV):    begin dec = P_LEFT;    ok = 1'b1; end
      CMD_W'(CMD_NEXT):    begin dec = P_RIGHT;   ok = 1'b1; end
      default:             begin dec = '0;        ok = 1'b0; end
    endcase
  end

  // Next state, capture strobes and pulse setup
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    pls_d   = '0;
    cur_d   = cur_q;
    ack0    = 1'b0;
    ack1    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_v && !reset) begin
          ack0   = ~gnt_id;
          ack1   = gnt_id;
          last_d = gnt_id;
          if (ok) begin
            state_d = ST_ISSUE;
            pls_d   = dec;
            cur_d   = sel_cur;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_SETTLE;
        cnt_d   = 4'(SETTLE - 1);
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      pls_q   <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      pls_q   <= pls_d;
      cur_q   <= cur_d;
    end
  end

  assign {game_area, retract, retry, left, right} = pls_q;
  assign cursor = cur_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_game_cmd_sequencer.sv
// Scoreboard bench: a cycle-level model predicts acks, pulses and
// status; a monitor pops and compares whatever the DUT presents.
module tb_game_cmd_sequencer;

  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, win = 1'b0;
  logic [2:0] cmd0 = '0, cmd1 = '0;
  logic [5:0] cur0 = '0, cur1 = '0;
  logic       ack0, ack1, busy, drop;
  logic       game_area, retract, retry, left, right;
  logic [5:0] cursor;

  game_cmd_sequencer #(.SETTLE(SETTLE), .CMD_W(3)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .cmd0(cmd0), .cur0(cur0), .ack0(ack0),
    .req1(req1), .cmd1(cmd1), .cur1(cur1), .ack1(ack1),
    .win(win), .cursor(cursor),
    .game_area(game_area), .retract(retract), .retry(retry),
    .left(left), .right(right), .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [4:0] pv; logic [5:0] cur; } pev_t;
  typedef struct { int cyc; bit id; bit drp; } aev_t;
  typedef struct { bit bsy; logic [5:0] cur; } sev_t;

  pev_t pq[$];
  aev_t aq[$];
  sev_t sq[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  bit         rq[2];
  logic [2:0] cm[2];
  logic [5:0] cu[2];
  bit         acked[2];

  // reference model state
  int         m_free = 0;
  bit         m_last = 1'b1;
  logic [5:0] m_cur = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic model_eval();
    sev_t s;
    aev_t a;
    pev_t p;
    bit   id;
    bit   okc;
    int   c;
    if (reset) begin
      pq.delete(); aq.delete(); sq.delete();
      m_free = 0; m_last = 1'b1; m_cur = '0;
      return;
    end
    s.bsy = (cyc < m_free);
    s.cur = m_cur;
    sq.push_back(s);
    if (cyc >= m_free && (rq[0] || rq[1])) begin
      id = (rq[0] && rq[1]) ? !m_last : rq[1];
      m_last = id;
      c = int'(cm[id]);
      okc = (c == 4 || c == 5) || (c >= 1 && c <= 3 && !win);
      a.cyc = cyc; a.id = id; a.drp = !okc;
      aq.push_back(a);
      if (okc) begin
        p.cyc = cyc + 1;
        p.pv  = 5'b10000 >> (c - 1);
        p.cur = cu[id];
        pq.push_back(p);
        m_cur  = cu[id];
        m_free = cyc + 2 + SETTLE;
      end
    end
  endtask

  task automatic step();
    req0 = rq[0]; cmd0 = cm[0]; cur0 = cu[0];
    req1 = rq[1]; cmd1 = cm[1]; cur1 = cu[1];
    @(negedge clk);
    model_eval();
    acked[0] = ack0;
    acked[1] = ack1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_ack(input int i);
    for (int k = 0; k < 40; k++) begin
      step();
      if (acked[i]) return;
    end
    chk("ack_timeout", 0, 1);
  endtask

  task automatic send(input int i, input logic [2:0] c,
                      input logic [5:0] u);
    rq[i] = 1'b1; cm[i] = c; cu[i] = u;
    wait_ack(i);
    rq[i] = 1'b0;
  endtask

  task automatic serve_both();
    for (int k = 0; k < 60; k++) begin
      step();
      for (int i = 0; i < 2; i++) if (acked[i]) rq[i] = 1'b0;
      if (!rq[0] && !rq[1]) return;
    end
    chk("tie_timeout", 0, 1);
  endtask

  // Monitor: pops expectations whenever the DUT shows something
  initial begin
    sev_t s;
    aev_t a;
    pev_t p;
    logic [4:0] pv;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        pv = {game_area, retract, retry, left, right};
        chk("pulse_onehot", ($countones(pv) <= 1), 1);
        if (sq.size() == 0) chk("status_missing", 0, 1);
        else begin
          s = sq.pop_front();
          chk("busy", busy, s.bsy);
          chk("cursor", cursor, s.cur);
        end
        if (ack0 || ack1 || drop) begin
          if (aq.size() == 0) chk("ack_unexpected", {ack1, ack0, drop}, 0);
          else begin
            a = aq.pop_front();
            chk("ack_cycle", cyc, a.cyc);
            chk("ack_id", {ack1, ack0}, a.id ? 2'b10 : 2'b01);
            chk("drop", drop, a.drp);
          end
        end
        if (pv != 5'b0) begin
          if (pq.size() == 0) chk("pulse_unexpected", pv, 0);
          else begin
            p = pq.pop_front();
            chk("pulse_cycle", cyc, p.cyc);
            chk("pulse_kind", pv, p.pv);
            chk("pulse_cursor", cursor, p.cur);
          end
        end
      end
    end
  end

  initial begin
    rq[0] = 0; rq[1] = 0; cm[0] = 0; cm[1] = 0; cu[0] = 0; cu[1] = 0;
    acked[0] = 0; acked[1] = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_cursor", cursor, 0);
    chk("rst_pulses", {game_area, retract, retry, left, right}, 0);
    chk("rst_ack", {ack0, ack1, drop}, 0);
    do_reset();

    send(0, 3'd1, 6'd27);
    for (int k = 0; k < 4; k++) step();

    do_reset();
    rq[0] = 1; cm[0] = 3'd2; cu[0] = 6'd9;
    rq[1] = 1; cm[1] = 3'd3; cu[1] = 6'd12;
    serve_both();
    rq[0] = 1; cm[0] = 3'd4; cu[0] = 6'd1;
    rq[1] = 1; cm[1] = 3'd5; cu[1] = 6'd2;
    serve_both();
    for (int k = 0; k < 4; k++) step();

    win = 1'b1;
    send(1, 3'd1, 6'd5);
    send(0, 3'd5, 6'd33);
    for (int k = 0; k < 4; k++) step();
    send(0, 3'd7, 6'd50);
    send(0, 3'd0, 6'd51);
    win = 1'b0;
    for (int k = 0; k < 4; k++) step();

    rq[0] = 1; cm[0] = 3'd3; cu[0] = 6'd44;
    wait_ack(0);
    #1;
    chk("issue_retry", retry, 1);
    reset = 1'b1;
    #1;
    chk("async_retry", retry, 0);
    chk("async_busy", busy, 0);
    chk("async_cursor", cursor, 0);
    chk("async_ack", {ack0, ack1, drop}, 0);
    step();
    step();
    reset = 1'b0;
    wait_ack(0);
    chk("reack_cycle", acked[0], 1);
    rq[0] = 0;
    for (int k = 0; k < 4; k++) step();

    rq[0] = 1; cm[0] = 3'd1; cu[0] = 6'd3;
    begin
      int n = 0;
      for (int k = 0; k < 100 && n < 5; k++) begin
        step();
        if (acked[0]) begin
          n++;
          cu[0] = 6'($urandom_range(0, 63));
        end
      end
      chk("b2b_count", n, 5);
    end
    rq[0] = 0;

    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rq[i] || acked[i]) begin
          rq[i] = ($urandom_range(0, 3) != 0);
          cm[i] = 3'($urandom_range(0, 7));
          cu[i] = 6'($urandom_range(0, 63));
        end
      end
      if ($urandom_range(0, 7) == 0) win = ~win;
      step();
    end

    rq[0] = 0; rq[1] = 0;
    for (int k = 0; k < 10; k++) step();
    chk("left_pulses", pq.size(), 0);
    chk("left_acks", aq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
